cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
Parametrised on-chip trace capture for the five-stage CPU, replacing fixed-length per-cycle monitoring of stage diagnostics.
- Samples NCH channels of pipeline diagnostic words (e.g. if_pc, if_instr, wb_regdata) into a DEPTH-entry circular buffer.
- Supports a programmable trigger with post-trigger count, PC-match or immediate trigger, and a fill-once mode.
- Contents are read out afterwards in oldest-first logical order.

Parameters:
WIDTH, 32, bits per channel
NCH, 4, number of channels captured per sample
DEPTH, 16, buffer entries; power of two, >= 4; AW = clog2(DEPTH)

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse; starts or restarts a capture
mode  in  2  0 immediate trigger, 1 match trigger, 2 fill-once, 3 treated as 0
trig_val  in  WIDTH  compare value for mode 1, matched against channel 0
post_cnt  in  8  qualified samples to capture after the trigger sample
sample_en  in  1  sample qualifier; low = no write (stall or bubble)
ch_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
rd_addr  in  AW  logical read index; 0 = oldest sample
rd_data  out  NCH*WIDTH  registered read data
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
done  out  1  equals (state == DONE)
count  out  AW+1  valid entries, saturating at DEPTH
wrapped  out  1  at least one entry has been overwritten
trig_idx  out  AW  logical index of the trigger sample; valid in DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, count=0, wrapped=0, trig_idx=0, rd_data=0; internal wr_ptr=0, post counter=0.
  - Buffer RAM is not cleared.
- arm=1 in any state:
  - Next cycle: state=ARMED, wr_ptr=0, count=0, wrapped=0.
  - mode, trig_val and post_cnt are latched. post_cnt is clamped to DEPTH-1.
  - The sample present on the arm cycle is not captured; arm takes priority over any other event that cycle.
- Qualified sample = sample_en=1 in state ARMED or POST. It writes ch_data to RAM[wr_ptr].
  - wr_ptr increments mod DEPTH.
  - count increments, saturating at DEPTH.
  - Writing when count==DEPTH sets wrapped=1.
- ARMED transitions:
  - mode 0/3: the first qualified sample is the trigger.
  - mode 1: a qualified sample with ch_data[WIDTH-1:0]==trig_val is the trigger.
  - The trigger sample is written. Then: POST if latched post_cnt>0, else DONE.
  - mode 2: never triggers. DONE on the cycle count reaches DEPTH, with no wrap; trig_idx=0.
- POST: each qualified sample decrements the post counter; DONE after the last one is written.
- DONE and IDLE: no writes; wr_ptr, count and wrapped are held.
- On entry to DONE, trig_idx = count - 1 - latched post_cnt, evaluated with the final count value.
- Readout (every cycle, all states):
  - phys = (count<DEPTH) ? rd_addr : (wr_ptr + rd_addr) mod DEPTH.
  - rd_data <= RAM[phys] on the next posedge (1-cycle latency).
  - rd_data <= 0 when rd_addr >= count.
- Write and read to the same entry in one cycle: rd_data returns the old contents (read-before-write).
- Reset asserted mid-capture aborts immediately. No partial-state recovery; a new arm is required.

Test Plan:
- Reset: DEPTH=8, NCH=2; pulse arm, capture 3 samples, drop rst_n -> state=0, count=0, done=0, rd_data=0 asynchronously; no capture until the next arm.
- Immediate trigger: mode 0, post_cnt=3, ch0 = 0x10,0x11,... with sample_en=1 every cycle after arm -> DONE after 4th sample; count=4, trig_idx=0, wrapped=0; rd_addr 0..3 -> ch0 0x10..0x13, one cycle after each address; rd_addr 4 -> 0.
- Match trigger with wrap: DEPTH=8, mode 1, trig_val=0x40, post_cnt=2, ch0 = 4k for k=0,1,2,... -> DONE after sample 0x48; count=8, wrapped=1, trig_idx=5; rd_addr 0 -> 0x2C, rd_addr 5 -> 0x40, rd_addr 7 -> 0x48.
- Qualifier gating: mode 2, sample_en alternating 1,0,1,0,... for 16 cycles, ch0 = cycle number 0..15 -> done on cycle 14's sample; count=8, wrapped=0; rd_addr 0..7 -> 0,2,4,...,14.
- Re-arm mid-capture: mode 0, post_cnt=6; arm again while in POST with 3 samples taken -> next cycle state=1, count=0; the new capture completes independently (count=7, trig_idx=0).
- Clamp: DEPTH=8, mode 0, post_cnt=20 -> DONE after exactly 8 qualified samples; count=8, wrapped=0, trig_idx=0.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Trace capture for the five-stage CPU: NCH diagnostic channels into a DEPTH-entry
// circular buffer with a programmable trigger, post-trigger window and oldest-first readout.
module cpu_trace_buffer #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     trig_val,
    input  logic [7:0]           post_cnt,
    input  logic                 sample_en,
    input  logic [NCH*WIDTH-1:0] ch_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [NCH*WIDTH-1:0] rd_data,
    output logic [1:0]           state,
    output logic                 done,
    output logic [AW:0]          count,
    output logic                 wrapped,
    output logic [AW-1:0]        trig_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [NCH*WIDTH-1:0] ram_r [DEPTH];
    logic [NCH*WIDTH-1:0] rd_data_r;
    state_t               state_r;
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        post_lat_r;
    logic [AW-1:0]        post_ctr_r;
    logic [AW-1:0]        trig_idx_r;
    logic [AW:0]          count_r;
    logic                 wrapped_r;
    logic                 done_r;
    logic [1:0]           mode_r;
    logic [WIDTH-1:0]     trig_val_r;

    logic                 qual_s;
    logic                 trig_s;
    logic                 fill_done_s;
    logic                 post_done_s;
    logic [AW:0]          count_nxt_s;
    logic [AW-1:0]        trig_idx_nxt_s;
    logic [AW-1:0]        phys_s;

    function automatic logic [AW-1:0] clamp_post(input logic [7:0] p);
        logic [31:0] v;
        v = ({24'd0, p} > 32'(DEPTH - 1)) ? 32'(DEPTH - 1) : {24'd0, p};
        return v[AW-1:0];
    endfunction

    // Sample qualification, trigger detection and read address translation.
    always_comb begin
        qual_s         = 1'b0;
        trig_s         = 1'b0;
        fill_done_s    = 1'b0;
        post_done_s    = 1'b0;
        count_nxt_s    = count_r;
        trig_idx_nxt_s = {AW{1'b0}};
        phys_s         = rd_addr;
        if (!arm && sample_en && (state_r == ST_ARMED || state_r == ST_POST)) begin
            qual_s = 1'b1;
        end else begin
            qual_s = 1'b0;
        end
        if (count_r == FULL) begin
            count_nxt_s = count_r;
        end else begin
            count_nxt_s = count_r + ONE;
        end
        case (mode_r)
            2'd1:    trig_s = (ch_data[WIDTH-1:0] == trig_val_r);
            2'd2:    trig_s = 1'b0;
            default: trig_s = 1'b1;
        endcase
        fill_done_s    = (mode_r == 2'd2) && (count_nxt_s == FULL);
        post_done_s    = (post_ctr_r == AW'(1));
        // Final count minus the post window locates the trigger in logical order.
        trig_idx_nxt_s = AW'(count_nxt_s - ONE - {1'b0, post_lat_r});
        if (count_r < FULL) begin
            phys_s = rd_addr;
        end else begin
            phys_s = wr_ptr_r + rd_addr;
        end
    end

    // Capture FSM with pointer, fill level and trigger bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            wrapped_r  <= 1'b0;
            trig_idx_r <= {AW{1'b0}};
            post_lat_r <= {AW{1'b0}};
            post_ctr_r <= {AW{1'b0}};
            done_r     <= 1'b0;
            mode_r     <= 2'd0;
            trig_val_r <= {WIDTH{1'b0}};
        end else if (arm) begin
            state_r    <= ST_ARMED;
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            wrapped_r  <= 1'b0;
            post_ctr_r <= {AW{1'b0}};
            done_r     <= 1'b0;
            mode_r     <= mode;
            trig_val_r <= trig_val;
            post_lat_r <= clamp_post(post_cnt);
        end else if (qual_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
            count_r  <= count_nxt_s;
            if (count_r == FULL) begin
                wrapped_r <= 1'b1;
            end
            case (state_r)
                ST_ARMED: begin
                    if (fill_done_s) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        trig_idx_r <= {AW{1'b0}};
                    end else if (trig_s) begin
                        if (post_lat_r != {AW{1'b0}}) begin
                            state_r    <= ST_POST;
                            post_ctr_r <= post_lat_r;
                        end else begin
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            trig_idx_r <= trig_idx_nxt_s;
                        end
                    end
                end
                ST_POST: begin
                    post_ctr_r <= post_ctr_r - AW'(1);
                    if (post_done_s) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        trig_idx_r <= trig_idx_nxt_s;
                    end
                end
                default: begin
                    state_r <= state_r;
                end
            endcase
        end
    end

    // Trace RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (qual_s) begin
            ram_r[wr_ptr_r] <= ch_data;
        end
    end

    // Registered readout; old contents win on a same-cycle write to the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {(NCH*WIDTH){1'b0}};
        end else if ({1'b0, rd_addr} >= count_r) begin
            rd_data_r <= {(NCH*WIDTH){1'b0}};
        end else begin
            rd_data_r <= ram_r[phys_s];
        end
    end

    assign rd_data  = rd_data_r;
    assign state    = state_r;
    assign done     = done_r;
    assign count    = count_r;
    assign wrapped  = wrapped_r;
    assign trig_idx = trig_idx_r;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based capture model.
module tb_cpu_trace_buffer;

    localparam int W  = 32;
    localparam int N  = 2;
    localparam int D  = 8;
    localparam int AW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           arm = 1'b0;
    logic [1:0]     mode = 2'd0;
    logic [W-1:0]   trig_val = '0;
    logic [7:0]     post_cnt = 8'd0;
    logic           sample_en = 1'b0;
    logic [N*W-1:0] ch_data = '0;
    logic [AW-1:0]  rd_addr = '0;
    logic [N*W-1:0] rd_data;
    logic [1:0]     state;
    logic           done;
    logic [AW:0]    count;
    logic           wrapped;
    logic [AW-1:0]  trig_idx;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_trace_buffer #(.WIDTH(W), .NCH(N), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .mode(mode), .trig_val(trig_val),
        .post_cnt(post_cnt), .sample_en(sample_en), .ch_data(ch_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .state(state), .done(done),
        .count(count), .wrapped(wrapped), .trig_idx(trig_idx)
    );

    always #5 clk = ~clk;

    // Capture model: the buffer is the list of retained samples, oldest first.
    logic [N*W-1:0] m_q[$];
    int             m_state = 0;
    bit             m_wrapped = 1'b0;
    int             m_trig = 0;
    int             m_mode = 0;
    logic [W-1:0]   m_tv = '0;
    int             m_post = 0;
    int             m_left = 0;
    int             m_total = 0;
    int             m_trig_abs = 0;
    logic [N*W-1:0] m_rd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_finish();
        m_state = 3;
        m_trig  = m_trig_abs - (m_total - m_q.size());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_state = 0; m_wrapped = 1'b0; m_trig = 0; m_left = 0; m_rd = '0;
        end else begin
            m_rd = (int'(rd_addr) < m_q.size()) ? m_q[rd_addr] : '0;
            if (arm) begin
                m_q.delete();
                m_state = 1; m_wrapped = 1'b0; m_total = 0; m_left = 0;
                m_mode = (mode == 2'd3) ? 0 : int'(mode);
                m_tv   = trig_val;
                m_post = (int'(post_cnt) > D - 1) ? D - 1 : int'(post_cnt);
            end else if (sample_en && (m_state == 1 || m_state == 2)) begin
                if (m_q.size() == D) begin
                    void'(m_q.pop_front());
                    m_wrapped = 1'b1;
                end
                m_q.push_back(ch_data);
                m_total++;
                if (m_state == 1) begin
                    if (m_mode == 2) begin
                        if (m_q.size() == D) begin
                            m_state = 3;
                            m_trig  = 0;
                        end
                    end else if (m_mode == 0 || ch_data[W-1:0] == m_tv) begin
                        m_trig_abs = m_total - 1;
                        m_left     = m_post;
                        if (m_left == 0) model_finish();
                        else m_state = 2;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) model_finish();
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("state", 64'(state), 64'(m_state));
        check("done", 64'(done), 64'(m_state == 3));
        check("count", 64'(count), 64'(m_q.size()));
        check("wrapped", 64'(wrapped), 64'(m_wrapped));
        check("rd_data", rd_data, m_rd);
        if (m_state == 3) check("trig_idx", 64'(trig_idx), 64'(m_trig));
    end

    task automatic step(input logic a, input logic en, input logic [31:0] d0);
        arm = a; sample_en = en; ch_data = {d0 ^ 32'hA5A5_0000, d0};
        @(negedge clk);
    endtask

    task automatic start(input logic [1:0] md, input logic [31:0] tv, input logic [7:0] pc);
        mode = md; trig_val = tv; post_cnt = pc;
        step(1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-capture
        rd_addr = 3'd0;
        start(2'd0, 32'd0, 8'd10);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h10 + 32'(k));
        check("pre_reset_rd", 64'(rd_data[31:0]), 64'h10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h77);
        check("no_capture_state", 64'(state), 64'd0);
        check("no_capture_count", 64'(count), 64'd0);

        // Immediate trigger
        start(2'd0, 32'd0, 8'd3);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'h10 + 32'(k));
        check("imm_state", 64'(state), 64'd3);
        check("imm_count", 64'(count), 64'd4);
        check("imm_trig_idx", 64'(trig_idx), 64'd0);
        check("imm_wrapped", 64'(wrapped), 64'd0);
        for (int a = 0; a < 5; a++) begin
            rd_addr = 3'(a);
            step(1'b0, 1'b0, 32'd0);
            check("imm_rd", 64'(rd_data[31:0]), (a < 4) ? 64'(32'h10 + 32'(a)) : 64'd0);
        end

        // Match trigger with wrap
        start(2'd1, 32'h40, 8'd2);
        for (int k = 0; k < 19; k++) step(1'b0, 1'b1, 32'(4 * k));
        check("match_state", 64'(state), 64'd3);
        check("match_count", 64'(count), 64'd8);
        check("match_wrapped", 64'(wrapped), 64'd1);
        check("match_trig_idx", 64'(trig_idx), 64'd5);
        rd_addr = 3'd0; step(1'b0, 1'b0, 32'd0);
        check("match_rd0", 64'(rd_data[31:0]), 64'h2C);
        rd_addr = 3'd5; step(1'b0, 1'b0, 32'd0);
        check("match_rd5", 64'(rd_data[31:0]), 64'h40);
        rd_addr = 3'd7; step(1'b0, 1'b0, 32'd0);
        check("match_rd7", 64'(rd_data[31:0]), 64'h48);
        check("match_rd7_ch1", 64'(rd_data[63:32]), 64'(32'h48 ^ 32'hA5A5_0000));

        // Qualifier gating in fill-once mode
        start(2'd2, 32'd0, 8'd0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, (k % 2) == 0, 32'(k));
            if (k == 12) check("gate_not_done", 64'(done), 64'd0);
            if (k == 14) check("gate_done", 64'(done), 64'd1);
        end
        check("gate_count", 64'(count), 64'd8);
        check("gate_wrapped", 64'(wrapped), 64'd0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            step(1'b0, 1'b0, 32'd0);
            check("gate_rd", 64'(rd_data[31:0]), 64'(2 * a));
        end

        // Re-arm during the post-trigger window
        start(2'd0, 32'd0, 8'd6);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h100 + 32'(k));
        check("rearm_post", 64'(state), 64'd2);
        start(2'd0, 32'd0, 8'd6);
        check("rearm_state", 64'(state), 64'd1);
        check("rearm_count", 64'(count), 64'd0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 32'h200 + 32'(k));
        check("rearm_done", 64'(state), 64'd3);
        check("rearm_count7", 64'(count), 64'd7);
        check("rearm_trig_idx", 64'(trig_idx), 64'd0);

        // Post count clamp
        start(2'd0, 32'd0, 8'd20);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 32'h300 + 32'(k));
        check("clamp_not_done", 64'(state), 64'd2);
        step(1'b0, 1'b1, 32'h307);
        check("clamp_done", 64'(state), 64'd3);
        check("clamp_count", 64'(count), 64'd8);
        check("clamp_wrapped", 64'(wrapped), 64'd0);
        check("clamp_trig_idx", 64'(trig_idx), 64'd0);

        // Randomized phase, checked by the every-cycle compare against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            mode     = 2'($urandom_range(0, 3));
            trig_val = 32'($urandom_range(0, 7));
            post_cnt = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 10));
            rd_addr  = 3'($urandom_range(0, 7));
            arm       = ($urandom_range(0, 39) == 0);
            sample_en = ($urandom_range(0, 9) < 7);
            ch_data   = {32'($urandom), 32'($urandom_range(0, 7))};
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
